// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mem_pkg
//  Purpose  : Shared types and helpers for the data-memory responder.
//             - state_t        : responder FSM states (IDLE, WAIT, RESP)
//             - WORD_BYTES     : bytes per memory word
//             - addr_err()     : misalignment / out-of-range address check
//  Revision : 1.0  initial release
// ============================================================================
package riscv_mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A byte address is bad when it is not word aligned, or when any bit above
  // the word-index field is set (the access would fall outside the array).
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] w_hi;
    w_hi = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (w_hi != 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_dmem_array
//  Purpose  : Word-organised data RAM, DEPTH x 32 bits, no reset.
//             Synchronous write with per-byte enables, combinational read.
//  Ports    : clk      - clock, rising edge
//             i_we     - write strobe
//             i_be     - byte enables, bit i covers data[8i+7:8i]
//             i_widx   - word index for both read and write
//             i_wdata  - write data
//             o_rdata  - word currently stored at i_widx
//  Revision : 1.0  initial release
// ============================================================================
module riscv_dmem_array
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [WORD_BYTES-1:0] i_be,
  input  logic [AW-1:0]         i_widx,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (i_be[b]) begin
          r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_widx];

endmodule
`default_nettype wire

// File: rtl/riscv_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_dmem_responder
//  Purpose  : Target-side data-memory responder for the core's load/store
//             port. One request at a time over a valid/ready handshake, a
//             fixed access latency, word loads and byte-enabled stores, and
//             a response over a second valid/ready handshake.
//  Ports    : clk, reset (synchronous, active-low)
//             i_req_valid / o_req_ready        request handshake
//             i_req_write, i_req_addr, i_req_wdata, i_req_be  request payload
//             o_rsp_valid / i_rsp_ready        response handshake
//             o_rsp_rdata, o_rsp_err           response payload
//  Options  : RISCV_DMEM_STATS_EN adds o_stat_loads, o_stat_stores and
//             o_stat_errors (16-bit saturating commit counters).
//  Revision : 1.0  initial release
// ============================================================================
module riscv_dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [31:0]           i_req_addr,
  input  logic [31:0]           i_req_wdata,
  input  logic [WORD_BYTES-1:0] i_req_be,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_err
`ifdef RISCV_DMEM_STATS_EN
  ,
  output logic [15:0]           o_stat_loads,
  output logic [15:0]           o_stat_stores,
  output logic [15:0]           o_stat_errors
`endif
);

  // WAIT always lasts WAIT_CYCLES+1 edges: the counter is loaded with
  // WAIT_CYCLES and the commit happens on the edge that sees it at zero,
  // so rsp_valid rises WAIT_CYCLES+1 edges after the accept edge.
  localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

  state_t                r_state;
  logic                  r_req_ready;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [WORD_BYTES-1:0] r_be;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_accept;
  logic                  w_err;
  logic                  w_commit;
  logic                  w_we;
  logic [31:0]           w_rdata;

  assign w_accept = (r_state == IDLE) && i_req_valid && r_req_ready;
  assign w_err    = addr_err(r_addr, AW);
  assign w_commit = (r_state == WAIT) && (r_cnt == 4'd0) && reset;
  // Bad addresses never touch the array.
  assign w_we     = w_commit && r_write && !w_err;

  riscv_dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (r_be),
    .i_widx  (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_cnt       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write     <= i_req_write;
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_wdata;
            r_be        <= i_req_be;
            r_cnt       <= c_wait_init;
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || r_write) ? 32'd0 : w_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

`ifdef RISCV_DMEM_STATS_EN
  logic [15:0] r_stat_loads;
  logic [15:0] r_stat_stores;
  logic [15:0] r_stat_errors;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_loads  <= 16'd0;
      r_stat_stores <= 16'd0;
      r_stat_errors <= 16'd0;
    end else if (w_commit) begin
      if (w_err) begin
        if (r_stat_errors != 16'hFFFF) r_stat_errors <= r_stat_errors + 16'd1;
      end else if (r_write) begin
        if (r_stat_stores != 16'hFFFF) r_stat_stores <= r_stat_stores + 16'd1;
      end else begin
        if (r_stat_loads != 16'hFFFF) r_stat_loads <= r_stat_loads + 16'd1;
      end
    end
  end

  assign o_stat_loads  = r_stat_loads;
  assign o_stat_stores = r_stat_stores;
  assign o_stat_errors = r_stat_errors;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_dmem_responder
//  Purpose  : Self-checking bench for riscv_dmem_responder (WAIT_CYCLES=2).
//             Table of request vectors plus hand sequences for response
//             back-pressure and reset in the middle of an access.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_dmem_responder;

  localparam int LAT = 3;  // WAIT_CYCLES + 1

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_be;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
`ifdef RISCV_DMEM_STATS_EN
  logic [15:0] o_stat_loads;
  logic [15:0] o_stat_stores;
  logic [15:0] o_stat_errors;
`endif

  always #5 clk = ~clk;

  riscv_dmem_responder #(
    .DEPTH       (256),
    .WAIT_CYCLES (2),
    .AW          (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_write (i_req_write),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .i_req_be    (i_req_be),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err)
`ifdef RISCV_DMEM_STATS_EN
    ,
    .o_stat_loads  (o_stat_loads),
    .o_stat_stores (o_stat_stores),
    .o_stat_errors (o_stat_errors)
`endif
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  int   checks = 0;
  int   errors = 0;
  rsp_t sb[$];
  int   m_loads = 0, m_stores = 0, m_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_timeout", {31'd0, o_req_ready}, 32'd1);
  endtask

  task automatic run_req(input vec_t v);
    int   n;
    rsp_t e;
    wait_ready();
    i_req_valid = 1'b1;
    i_req_write = v.write;
    i_req_addr  = v.addr;
    i_req_wdata = v.wdata;
    i_req_be    = v.be;
    @(posedge clk); #1;
    // Scramble the request bus: the DUT must use its latched copy.
    i_req_valid = 1'b0;
    i_req_write = ~v.write;
    i_req_addr  = $urandom;
    i_req_wdata = $urandom;
    i_req_be    = 4'($urandom);
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    if (v.exp_err) m_errs++;
    else if (v.write) m_stores++;
    else m_loads++;
    n = 0;
    while (!o_rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, LAT);
    for (int k = 0; k < v.hold; k++) begin
      chk("hold_valid", {31'd0, o_rsp_valid}, 32'd1);
      chk("hold_rdata", o_rsp_rdata, v.exp_rdata);
      chk("hold_req_ready", {31'd0, o_req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    chk("rsp_rdata", o_rsp_rdata, e.rdata);
    chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, e.err});
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    chk("rsp_cleared_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rsp_cleared_rdata", o_rsp_rdata, 32'd0);
    chk("req_ready_after_rsp", {31'd0, o_req_ready}, 32'd1);
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, input logic [31:0] er,
                              input logic ee, input int h);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.be = be;
    v.exp_rdata = er; v.exp_err = ee; v.hold = h;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    vecs[0]  = mk(1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 0);
    vecs[1]  = mk(1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 5);
    vecs[2]  = mk(1'b1, 32'h10,  32'h11223344, 4'hF, 32'h0,        1'b0, 0);
    vecs[3]  = mk(1'b1, 32'h10,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 0);
    vecs[4]  = mk(1'b0, 32'h10,  32'h0,        4'h0, 32'h11BB33DD, 1'b0, 0);
    vecs[5]  = mk(1'b0, 32'h13,  32'h0,        4'hF, 32'h0,        1'b1, 0);
    vecs[6]  = mk(1'b0, 32'h400, 32'h0,        4'hF, 32'h0,        1'b1, 0);
    vecs[7]  = mk(1'b1, 32'h13,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 0);
    vecs[8]  = mk(1'b0, 32'h10,  32'h0,        4'h0, 32'h11BB33DD, 1'b0, 2);
    vecs[9]  = mk(1'b1, 32'h10,  32'h00000000, 4'h0, 32'h0,        1'b0, 0);
    vecs[10] = mk(1'b0, 32'h10,  32'h0,        4'hA, 32'h11BB33DD, 1'b0, 0);
    vecs[11] = mk(1'b1, 32'h20,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 0);
    vecs[12] = mk(1'b0, 32'h20,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 0);

    reset       = 1'b0;
    i_req_valid = 1'b0;
    i_req_write = 1'b0;
    i_req_addr  = 32'd0;
    i_req_wdata = 32'd0;
    i_req_be    = 4'd0;
    i_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'd0, o_req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, o_rsp_err}, 32'd0);
`ifdef RISCV_DMEM_STATS_EN
    chk("reset_stat_loads", {16'd0, o_stat_loads}, 32'd0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 13; i++) run_req(vecs[i]);

`ifdef RISCV_DMEM_STATS_EN
    chk("stat_loads", {16'd0, o_stat_loads}, m_loads);
    chk("stat_stores", {16'd0, o_stat_stores}, m_stores);
    chk("stat_errors", {16'd0, o_stat_errors}, m_errs);
`endif

    // Reset while in WAIT: the store to 0x20 must be aborted.
    wait_ready();
    i_req_valid = 1'b1;
    i_req_write = 1'b1;
    i_req_addr  = 32'h20;
    i_req_wdata = 32'h12345678;
    i_req_be    = 4'hF;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midreset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("midreset_req_ready", {31'd0, o_req_ready}, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_idle_ready", {31'd0, o_req_ready}, 32'd1);
    chk("midreset_rsp_valid2", {31'd0, o_rsp_valid}, 32'd0);
`ifdef RISCV_DMEM_STATS_EN
    chk("midreset_stat_stores", {16'd0, o_stat_stores}, 32'd0);
`endif
    run_req(mk(1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
